// File: rtl/libv_arb_rr_if.sv
// libv_arb_rr_if: requester/consumer handshake bundle for libv_arb_rr
// The req_last signal exists only when LIBV_ARB_RR_PKT_EN is defined.
interface libv_arb_rr_if #(parameter int N = 4);
    localparam int W_ENC = (N > 1) ? $clog2(N) : 1;
    logic [N-1:0] req_vld;
    logic [N-1:0] req_rdy;
    logic [N-1:0] gnt;
    logic [W_ENC-1:0] gnt_enc;
    logic out_vld;
    logic out_rdy;
`ifdef LIBV_ARB_RR_PKT_EN
    logic [N-1:0] req_last;
    modport slave (input req_vld, req_last, out_rdy, output req_rdy, gnt, gnt_enc, out_vld);
    modport master (output req_vld, req_last, out_rdy, input req_rdy, gnt, gnt_enc, out_vld);
`else
    modport slave (input req_vld, out_rdy, output req_rdy, gnt, gnt_enc, out_vld);
    modport master (output req_vld, out_rdy, input req_rdy, gnt, gnt_enc, out_vld);
`endif
endinterface

// File: rtl/libv_arb_rr.sv
// libv_arb_rr: round-robin valid/ready arbiter producing the one-hot libv_mux select
// Define LIBV_ARB_RR_PKT_EN to hold the grant across multi-beat packets via req_last.
module libv_arb_rr #(
    parameter int N = 4
) (
    input logic clk,
    input logic rst,
    libv_arb_rr_if.slave bus
);
    localparam int W_ENC = (N > 1) ? $clog2(N) : 1;
    logic [W_ENC-1:0] ptr_q, ptr_d, enc, ptr_nxt;
    logic lock_q, lock_d;
    logic [N-1:0] gnt_q, gnt_d, arb, gnt;
    logic out_vld;
    always_comb begin
        arb = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr_q) + k) % N;
            if (bus.req_vld[j]) arb = N'(1) << j;
        end
    end
    always_comb begin
        gnt = lock_q ? gnt_q : arb;
        out_vld = lock_q ? |(gnt_q & bus.req_vld) : |bus.req_vld;
        enc = '0;
        for (int i = 0; i < N; i++)
            if (gnt[i]) enc = W_ENC'(i);
        ptr_nxt = (enc == W_ENC'(N - 1)) ? '0 : enc + W_ENC'(1);
    end
    assign bus.gnt = gnt;
    assign bus.gnt_enc = enc;
    assign bus.out_vld = out_vld;
    assign bus.req_rdy = gnt & {N{bus.out_rdy}};
    always_comb begin
        ptr_d = ptr_q;
        lock_d = lock_q;
        gnt_d = gnt_q;
        if (out_vld && !bus.out_rdy) begin
            lock_d = 1'b1;
            gnt_d = gnt;
        end else if (out_vld) begin
`ifdef LIBV_ARB_RR_PKT_EN
            // a non-final beat keeps the same requester so packets never interleave
            lock_d = ~|(gnt & bus.req_last);
            gnt_d = gnt;
            ptr_d = lock_d ? ptr_q : ptr_nxt;
`else
            lock_d = 1'b0;
            ptr_d = ptr_nxt;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            lock_q <= 1'b0;
            gnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            lock_q <= lock_d;
            gnt_q <= gnt_d;
        end
    end
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_vld_onehot: assert property (@(posedge clk) disable iff (rst) out_vld |-> $onehot(gnt));
    a_hold_vld: assert property (@(posedge clk) disable iff (rst) !(lock_q && !(|(gnt_q & bus.req_vld))));
endmodule
